// File: rtl/jtdsp16_rom_seq.sv
// JTDSP16 program sequencer: pc/ROM address, call stack, counted do-loop, table pointer and interrupt entry.
// Single-cycle, gated by cen. Define JTDSP16_IRQ_STK_EN to save the interrupt return address on the call stack instead of pi.
module jtdsp16_rom_seq #(
    parameter int AW      = 16,
    parameter int JW      = 12,
    parameter int SD      = 4,
    parameter int IRQ_VEC = 1
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     cen,
    input  logic                     jmp,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     iret,
    input  logic [JW-1:0]            j_field,
    input  logic                     halt,
    input  logic                     do_start,
    input  logic [7:0]               do_cnt,
    input  logic [3:0]               do_len,
    input  logic                     ext_irq,
    input  logic                     no_int,
    input  logic                     pt_load,
    input  logic [AW-1:0]            pt_din,
    input  logic                     pt_read,
    input  logic                     pt_step,
    input  logic                     i_load,
    input  logic [11:0]              i_din,
    output logic [AW-1:0]            rom_addr,
    output logic [AW-1:0]            pt_addr,
    output logic                     iack,
    output logic                     in_irq,
    output logic                     lp_active,
    output logic [$clog2(SD+1)-1:0]  stk_level,
    output logic                     stk_ovf,
    output logic                     stk_unf
);
    localparam int LW = $clog2(SD+1);
    localparam int PW = $clog2(SD);

    logic [AW-1:0] pc, pt, pi, lp_start, lp_end;
    logic [11:0]   i;
    logic [8:0]    lp_cnt;
    logic [AW-1:0] stk [SD];
    logic [PW-1:0] wp;
    logic [LW-1:0] level;

    logic [AW-1:0] pc_inc, jt, top, base_next, next_pc, wr_a_val, wr_b_val, pt_inc;
    logic [PW-1:0] wp_dec, wp_a, slot_b, wp_n;
    logic [LW-1:0] lvl_a, lvl_n;
    logic [LW:0]   lvl_sum;
    logic [1:0]    npush;
    logic          enter_int, pop_req, pop, unf_set, ovf_set, lp_back, lp_exit;
    logic          wr_a_en, wr_b_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SD-1)) ? '0 : p + 1'b1;
    endfunction

    assign pc_inc    = pc + 1'b1;
    assign jt        = {pc[AW-1:JW], j_field};
    assign wp_dec    = (wp == '0) ? PW'(SD-1) : wp - 1'b1;
    assign top       = stk[wp_dec];
    assign enter_int = ext_irq & ~in_irq & ~no_int & ~lp_active & ~halt;
    assign pt_inc    = pt_step ? {{(AW-12){i[11]}}, i} : AW'(1);

    // base_next is the target with interrupt entry ignored; it becomes the interrupt return address.
    always_comb begin
        base_next = pc_inc;
        pop_req   = 1'b0;
        lp_back   = 1'b0;
        lp_exit   = 1'b0;
        if (iret) begin
`ifdef JTDSP16_IRQ_STK_EN
            pop_req = 1'b1;
`else
            base_next = pi;
`endif
        end else if (jmp || call) begin
            base_next = jt;
        end else if (ret) begin
            pop_req = 1'b1;
        end else if (lp_active && pc == lp_end && !halt) begin
            if (lp_cnt > 9'd1) begin
                base_next = lp_start;
                lp_back   = 1'b1;
            end else begin
                lp_exit = 1'b1;
            end
        end else if (halt) begin
            base_next = pc;
        end
        pop     = 1'b0;
        unf_set = 1'b0;
        if (pop_req) begin
            if (level != '0) begin
                base_next = top;
                pop       = 1'b1;
            end else begin
                base_next = pc_inc;
                unf_set   = 1'b1;
            end
        end
        next_pc = enter_int ? AW'(IRQ_VEC) : base_next;
    end

    // Stack update: pop first, then up to two pushes (call return, then interrupt return).
    always_comb begin
        wp_a     = pop ? wp_dec : wp;
        lvl_a    = pop ? level - 1'b1 : level;
        slot_b   = ptr_inc(wp_a);
        wr_a_en  = call;
        wr_a_val = pc_inc;
        wr_b_en  = 1'b0;
        wr_b_val = base_next;
`ifdef JTDSP16_IRQ_STK_EN
        if (enter_int) begin
            if (call) begin
                wr_b_en = 1'b1;
            end else begin
                wr_a_en  = 1'b1;
                wr_a_val = base_next;
            end
        end
`endif
        npush   = {1'b0, wr_a_en} + {1'b0, wr_b_en};
        lvl_sum = {1'b0, lvl_a} + (LW+1)'(npush);
        ovf_set = lvl_sum > (LW+1)'(SD);
        lvl_n   = ovf_set ? LW'(SD) : lvl_sum[LW-1:0];
        case (npush)
            2'd1:    wp_n = slot_b;
            2'd2:    wp_n = ptr_inc(slot_b);
            default: wp_n = wp_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            pt        <= '0;
            i         <= '0;
            pi        <= '0;
            lp_start  <= '0;
            lp_end    <= '0;
            lp_cnt    <= '0;
            lp_active <= 1'b0;
            wp        <= '0;
            level     <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
            iack      <= 1'b0;
            in_irq    <= 1'b0;
            for (int k = 0; k < SD; k++) stk[k] <= '0;
        end else if (cen) begin
            pc   <= next_pc;
            iack <= enter_int;
            if (enter_int) begin
                in_irq <= 1'b1;
`ifndef JTDSP16_IRQ_STK_EN
                pi     <= base_next;
`endif
            end else if (iret) begin
                in_irq <= 1'b0;
            end

            if (wr_a_en) stk[wp_a] <= wr_a_val;
            if (wr_b_en) stk[slot_b] <= wr_b_val;
            wp    <= wp_n;
            level <= lvl_n;
            if (ovf_set) stk_ovf <= 1'b1;
            if (unf_set) stk_unf <= 1'b1;

            if (do_start && !lp_active) begin
                lp_start  <= pc_inc;
                lp_end    <= pc + AW'((do_len == 4'd0) ? 4'd1 : do_len);
                lp_cnt    <= (do_cnt == 8'd0) ? 9'd256 : {1'b0, do_cnt};
                lp_active <= 1'b1;
            end else if (lp_back) begin
                lp_cnt <= lp_cnt - 1'b1;
            end else if (lp_exit) begin
                lp_active <= 1'b0;
            end

            if (pt_load)      pt <= pt_din;
            else if (pt_read) pt <= pt + pt_inc;
            if (i_load) i <= i_din;
        end
    end

    assign rom_addr  = pc;
    assign pt_addr   = pt;
    assign stk_level = level;
endmodule

// File: tb/tb_jtdsp16_rom_seq.sv
// Directed self-checking bench for jtdsp16_rom_seq (default build, AW=16 JW=12 SD=4 IRQ_VEC=1).
module tb_jtdsp16_rom_seq;
    logic        rst, clk, cen, jmp, call, ret, iret, halt, do_start;
    logic [11:0] j_field;
    logic [7:0]  do_cnt;
    logic [3:0]  do_len;
    logic        ext_irq, no_int, pt_load, pt_read, pt_step, i_load;
    logic [15:0] pt_din;
    logic [11:0] i_din;
    logic [15:0] rom_addr, pt_addr;
    logic        iack, in_irq, lp_active, stk_ovf, stk_unf;
    logic [2:0]  stk_level;

    int passed = 0;
    int total  = 0;

    jtdsp16_rom_seq #(.AW(16), .JW(12), .SD(4), .IRQ_VEC(1)) dut (
        .rst(rst), .clk(clk), .cen(cen), .jmp(jmp), .call(call), .ret(ret), .iret(iret),
        .j_field(j_field), .halt(halt), .do_start(do_start), .do_cnt(do_cnt), .do_len(do_len),
        .ext_irq(ext_irq), .no_int(no_int), .pt_load(pt_load), .pt_din(pt_din),
        .pt_read(pt_read), .pt_step(pt_step), .i_load(i_load), .i_din(i_din),
        .rom_addr(rom_addr), .pt_addr(pt_addr), .iack(iack), .in_irq(in_irq),
        .lp_active(lp_active), .stk_level(stk_level), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        jmp = 0; call = 0; ret = 0; iret = 0; halt = 0; do_start = 0;
        no_int = 0; pt_load = 0; pt_read = 0; pt_step = 0; i_load = 0;
    endtask

    logic [15:0] call_tgt [5] = '{16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    logic [15:0] ret_exp  [4] = '{16'h0701, 16'h0601, 16'h0501, 16'h0401};
    logic [15:0] lp_pc    [6] = '{16'h0022, 16'h0021, 16'h0022, 16'h0021, 16'h0022, 16'h0023};
    logic        lp_act   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1; cen = 0; idle(); ext_irq = 0;
        j_field = '0; do_cnt = '0; do_len = '0; pt_din = '0; i_din = '0;
        #12;
        chk("rst_pc", rom_addr, 0);
        chk("rst_pt", pt_addr, 0);
        chk("rst_lvl", stk_level, 0);
        chk("rst_flags", {stk_ovf, stk_unf, iack, in_irq, lp_active}, 0);
        rst = 0; cen = 1;

        for (int k = 1; k <= 5; k++) begin
            step();
            chk("seq_pc", rom_addr, k);
        end
        cen = 0; step();
        chk("cen_hold", rom_addr, 5);
        cen = 1;

        jmp = 1; j_field = 12'h010; step();
        chk("jmp_10", rom_addr, 16'h0010);
        j_field = 12'h234; step();
        chk("jmp_234", rom_addr, 16'h0234);
        jmp = 0; call = 1; j_field = 12'h100; step();
        chk("call_pc", rom_addr, 16'h0100);
        chk("call_lvl", stk_level, 1);
        call = 0; ret = 1; step();
        chk("ret_pc", rom_addr, 16'h0235);
        chk("ret_lvl", stk_level, 0);
        ret = 0;

        for (int k = 0; k < 5; k++) begin
            call = 1; j_field = call_tgt[k][11:0]; step();
            chk("nest_pc", rom_addr, call_tgt[k]);
            chk("nest_ovf", stk_ovf, (k == 4));
        end
        chk("nest_lvl", stk_level, 4);
        call = 0; ret = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("pop_pc", rom_addr, ret_exp[k]);
        end
        chk("pop_unf0", stk_unf, 0);
        step();
        chk("unf_pc", rom_addr, 16'h0402);
        chk("unf_flag", stk_unf, 1);
        chk("unf_lvl", stk_level, 0);
        ret = 0;

        jmp = 1; j_field = 12'h020; step();
        chk("lp_jmp", rom_addr, 16'h0020);
        jmp = 0; do_start = 1; do_cnt = 8'd3; do_len = 4'd2; step();
        chk("lp_first", rom_addr, 16'h0021);
        chk("lp_act0", lp_active, 1);
        do_start = 0; ext_irq = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("lp_pc", rom_addr, lp_pc[k]);
            chk("lp_act", lp_active, lp_act[k]);
            chk("lp_noack", iack, 0);
        end
        step();
        chk("irq_pc", rom_addr, 16'h0001);
        chk("irq_ack", iack, 1);
        chk("irq_in", in_irq, 1);
        ext_irq = 0; cen = 0; step();
        chk("ack_hold", iack, 1);
        cen = 1; step();
        chk("irq_pc2", rom_addr, 16'h0002);
        chk("ack_pulse", iack, 0);
        iret = 1; step();
        chk("iret_pc", rom_addr, 16'h0024);
        chk("iret_in", in_irq, 0);
        iret = 0;

        jmp = 1; j_field = 12'h040; step();
        chk("jmp_40", rom_addr, 16'h0040);
        ext_irq = 1; j_field = 12'h300; step();
        chk("irqj_pc", rom_addr, 16'h0001);
        chk("irqj_ack", iack, 1);
        ext_irq = 0; jmp = 0; halt = 1; step();
        chk("halt_pc", rom_addr, 16'h0001);
        chk("halt_ack", iack, 0);
        halt = 0; iret = 1; step();
        chk("irqj_ret", rom_addr, 16'h0300);
        chk("irqj_in", in_irq, 0);
        chk("sticky", {stk_ovf, stk_unf}, 2'b11);
        iret = 0;

        i_load = 1; i_din = 12'hFFE; pt_load = 1; pt_din = 16'h0010; step();
        chk("pt_load", pt_addr, 16'h0010);
        i_load = 0; pt_load = 0; pt_read = 1; pt_step = 1; step();
        chk("pt_dec1", pt_addr, 16'h000E);
        step();
        chk("pt_dec2", pt_addr, 16'h000C);
        i_load = 1; i_din = 12'h002; step();
        chk("pt_old_i", pt_addr, 16'h000A);
        i_load = 0; step();
        chk("pt_new_i", pt_addr, 16'h000C);
        pt_load = 1; pt_din = 16'hFFFF; pt_step = 0; step();
        chk("pt_ld_win", pt_addr, 16'hFFFF);
        pt_load = 0; step();
        chk("pt_wrap", pt_addr, 16'h0000);
        pt_read = 0;

        do_start = 1; do_cnt = 8'd5; do_len = 4'd3; step();
        chk("rst_lp_on", lp_active, 1);
        do_start = 0;
        #2 rst = 1; #1;
        chk("arst_lp", lp_active, 0);
        chk("arst_pc", rom_addr, 0);
        chk("arst_flg", {stk_ovf, stk_unf}, 0);
        chk("arst_pt", pt_addr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/jtdsp16_rom_seq.md
Name: jtdsp16_rom_seq

Overview:
- Parametrised program sequencer (XAAU successor) for the JTDSP16 core.
- Drives the ROM address and owns the pc, the table pointer pt and its step i, and the pi interrupt return register.
- New over the previous unit: a hardware call stack of depth SD with overflow/underflow flags, a counted do-loop with an end-address compare, and configurable address and jump-field widths.

Parameters:
AW, 16, address width of pc, pt, pi and the stack entries
JW, 12, jump field width; jump target = {pc[AW-1:JW], j_field}
SD, 4, call stack depth (entries), ≥2
IRQ_VEC, 1, interrupt vector address

Ports:
rst  in  1  async reset, active-high
clk  in  1  clock
cen  in  1  clock enable; all state advances only when cen=1
jmp  in  1  goto j_field
call  in  1  call j_field, pushes return address
ret  in  1  pop and jump
iret  in  1  return from interrupt
j_field  in  JW  jump target field
halt  in  1  hold pc (multi-cycle instruction)
do_start  in  1  start counted loop
do_cnt  in  8  iterations; 0 means 256
do_len  in  4  body length in instructions; 0 treated as 1
ext_irq  in  1  interrupt request, level
no_int  in  1  interrupts masked for this instruction
pt_load  in  1  pt <= pt_din
pt_din  in  AW  pt load data
pt_read  in  1  *pt++ / *pt++i access, post-modify pt
pt_step  in  1  post-modify by i instead of 1
i_load  in  1  i <= i_din
i_din  in  12  i load data
rom_addr  out  AW  ROM address (= pc)
pt_addr  out  AW  table pointer value
iack  out  1  one-cen-cycle pulse on interrupt entry
in_irq  out  1  servicing an interrupt
lp_active  out  1  loop active
stk_level  out  $clog2(SD+1)  current stack occupancy
stk_ovf  out  1  sticky overflow flag
stk_unf  out  1  sticky underflow flag

Behaviour:
- Reset: pc=0, pt=0, i=0, pi=0, stack empty (stk_level=0), flags 0, iack=0, in_irq=0, lp_active=0, loop counter 0.
- Single cycle: all updates occur on the clk edge with cen=1. rom_addr is the registered pc, with no extra latency.
- enter_int = ext_irq & !in_irq & !no_int & !lp_active & !halt.
- next_pc priority:
  - enter_int -> IRQ_VEC
  - iret -> pi
  - jmp|call -> {pc[AW-1:JW], j_field}
  - ret -> top of stack
  - loop-back -> lp_start
  - halt -> pc
  - else pc+1, wrapping modulo 2^AW
- Interrupt entry:
  - pi <= the next_pc computed with enter_int forced 0, so a coincident jump target or call is preserved.
  - A call coincident with entry still pushes.
  - in_irq<=1; iack=1 for exactly one cen cycle.
- iret clears in_irq. pi is writable only by interrupt entry.
- Call stack:
  - call pushes pc+1; stk_level increments.
  - Push at stk_level==SD overwrites the oldest entry (circular), stk_level stays SD, stk_ovf<=1.
  - ret pops; stk_level decrements.
  - ret at stk_level==0: next_pc=pc+1, stk_level stays 0, stk_unf<=1.
  - Flags clear only on reset.
- Do loop:
  - do_start with !lp_active: lp_start<=pc+1, lp_end<=pc+len, lp_cnt<=cnt, lp_active<=1.
  - do_start while active is ignored.
  - When lp_active & pc==lp_end & !halt & no higher-priority branch:
    - if lp_cnt>1: next_pc=lp_start, lp_cnt--;
    - else lp_active<=0 and next_pc=pc+1.
  - With cnt=1, the body executes once.
  - A jmp/call/ret inside the loop still branches; the loop stays active until the end compare.
- Table pointer:
  - pt_load wins over pt_read.
  - pt_read: pt <= pt + (pt_step ? sign_extend(i, AW) : 1), wrapping modulo 2^AW.
  - i_load and pt_read in the same cycle: pt uses the old i.
- cen=0: all registers hold; iack holds its value.
- Reset mid-loop or mid-interrupt returns all state to reset values immediately (async).

Optional Feature:
JTDSP16_IRQ_STK_EN
- Defined:
  - Interrupt entry pushes the preserved return address onto the call stack instead of pi, with the same overflow rules.
  - iret pops from the stack, with the same underflow rules.
  - pi holds its reset value.
- Undefined: pi-based behaviour as above, and the stack ignores interrupts.

Test Plan:
- Reset, then 5 cen cycles with no controls -> rom_addr 0,1,2,3,4,5; flags 0; stk_level 0.
- pc=0x0010, jmp with j_field=0x234 (AW=16, JW=12) -> pc=0x0234. call at 0x0234 to 0x100 -> pc=0x0100, stk_level=1. ret -> pc=0x0235, stk_level=0.
- SD=4: five nested calls -> stk_level=4, stk_ovf=1. Five rets -> first four return correctly (the oldest is lost), fifth sets stk_unf=1 and gives pc+1.
- do_start at pc=0x20, do_cnt=3, do_len=2 -> sequence 0x21,0x22,0x21,0x22,0x21,0x22,0x23; lp_active falls when leaving 0x22. ext_irq held throughout -> iack only after the loop ends.
- pc=0x40, ext_irq=1 with jmp to 0x300 in the same cycle -> pc=IRQ_VEC(1), iack=1 for one cycle, pi=0x300. iret -> pc=0x300, in_irq=0.
- i_load 0xFFE (−2), pt_load 0x0010, then pt_read with pt_step ×2 -> pt 0x000E, 0x000C. pt_read without pt_step at 0xFFFF -> 0x0000.
